// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the execute stage and muldiv_unit.
//   Request side : in_valid_i / in_ready_o handshake carrying op_i (funct3),
//                  a_i (rs1), b_i (rs2) and tag_i (rd address); flush_i aborts.
//   Response side: out_valid_o / out_ready_i handshake carrying result_o and
//                  tag_o; busy_o reports that the unit is not idle.
// The master modport belongs to the issuing pipeline, the slave modport to the
// unit.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [XLEN-1:0]  a_i;
  logic [XLEN-1:0]  b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport master (
    output in_valid_i, op_i, a_i, b_i, tag_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_i, a_i, b_i, tag_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU via radix-2
// shift-add, DIV/DIVU/REM/REMU via restoring shift-subtract, one bit per cycle
// on operand magnitudes with a sign correction at the end.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : muldiv_if slave modport (request, response, flush, busy)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_neg_q;   // product / quotient needs negation
  logic             r_neg_r;   // remainder needs negation (sign of a)
  logic             r_early;   // result already resolved at accept
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_out_valid;
  // Datapath: r_opnd is the fixed operand (|a| for multiply, |b| for divide),
  // {r_hi, r_lo} the working accumulator / remainder:quotient pair.
  logic [XLEN-1:0]  r_opnd;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // ---------------- accept decode ----------------
  logic            w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_early_res;

  assign w_accept   = (r_state == IDLE) && bus.in_valid_i && !bus.flush_i;
  assign w_is_div   = bus.op_i[2];
  assign w_a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                      (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
  assign w_b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
                      (bus.op_i == 3'b110);
  assign w_a_neg    = w_a_signed && bus.a_i[XLEN-1];
  assign w_b_neg    = w_b_signed && bus.b_i[XLEN-1];
  assign w_a_mag    = neg_if(w_a_neg, bus.a_i);
  assign w_b_mag    = neg_if(w_b_neg, bus.b_i);
  assign w_div0     = w_is_div && (bus.b_i == '0);
  assign w_ovf      = ((bus.op_i == 3'b100) || (bus.op_i == 3'b110)) &&
                      (bus.a_i == MIN_NEG) && (bus.b_i == '1);
  // op_i[1] separates REM/REMU from DIV/DIVU.
  assign w_early_res = w_div0 ? (bus.op_i[1] ? bus.a_i : '1)
                              : (bus.op_i[1] ? '0 : bus.a_i);

  // ---------------- iteration step ----------------
  logic [XLEN:0] w_mul_sum, w_shift, w_diff;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_shift   = {r_hi, r_lo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_opnd};

  // ---------------- final correction ----------------
  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_mul_res, w_div_res, w_final;

  assign w_prod    = {r_hi, r_lo};
  assign w_prod_c  = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_mul_res = (r_op == 3'b000) ? w_prod_c[XLEN-1:0] : w_prod_c[2*XLEN-1:XLEN];
  assign w_div_res = r_op[1] ? neg_if(r_neg_r, r_hi) : neg_if(r_neg_q, r_lo);
  assign w_final   = r_early ? r_lo : (r_op[2] ? w_div_res : w_mul_res);

  // ---------------- control FSM ----------------
  // Early cases skip the iterations by preloading the counter with its final
  // value, so they spend exactly one cycle in CALC before DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_early     <= 1'b0;
      r_result    <= '0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid_i) begin
            r_op    <= bus.op_i;
            r_tag   <= bus.tag_i;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_early <= w_div0 || w_ovf;
            r_cnt   <= (w_div0 || w_ovf) ? CNT_LAST : '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_cnt == CNT_LAST) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------- datapath (no reset needed) ----------------
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_hi <= '0;
      if (w_div0 || w_ovf) begin
        r_lo <= w_early_res;
      end else if (w_is_div) begin
        r_opnd <= w_b_mag;
        r_lo   <= w_a_mag;
      end else begin
        r_opnd <= w_a_mag;
        r_lo   <= w_b_mag;
      end
    end else if ((r_state == CALC) && (r_cnt != CNT_LAST)) begin
      if (r_op[2]) begin
        // Restoring divide: keep the subtraction only if it did not borrow.
        r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
      end else begin
        // Shift-add: multiplier bits leave r_lo as product bits enter it.
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign bus.in_ready_o  = (r_state == IDLE);
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.tag_o       = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: RISC-V M-extension semantics via 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    logic signed [31:0] q;
    sa = {{32{a[31]}}, a}; ua = {32'b0, a};
    sb = {{32{b[31]}}, b}; ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = $signed(a) / $signed(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drives one request, measures cycles from accept edge to out_valid_o,
  // captures result/tag, then completes the output handshake. lat=-1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] tg, output int lat);
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.tag_i = tag;
    bus.out_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.op_i = 3'($urandom); bus.a_i = $urandom; bus.b_i = $urandom; bus.tag_i = 5'($urandom);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) begin lat = i; break; end
    end
    res = bus.result_o;
    tg  = bus.tag_o;
    if (lat > 0) begin
      @(negedge clk); bus.out_ready_i = 1'b1;
      @(posedge clk); #1; bus.out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_tests++; if (bus.result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    n_tests++; if (bus.tag_o !== 5'h0) begin n_fail++; $display("FAIL reset_tag got=%h exp=0", bus.tag_o); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7,
                              32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [12] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'd1,
                              32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0};
    int          elat[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res; logic [4:0] tg; int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 3), res, tg, lat);
      n_tests++; if (res !== exp[i]) begin n_fail++; $display("FAIL directed_%0d_result op=%0d got=%h exp=%h", i, ops[i], res, exp[i]); end
      n_tests++; if (lat != elat[i]) begin n_fail++; $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, elat[i]); end
      n_tests++; if (tg !== 5'(i + 3)) begin n_fail++; $display("FAIL directed_%0d_tag got=%0d exp=%0d", i, tg, i + 3); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp; logic [2:0] op; logic [4:0] tag, tg; int lat;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7)); a = rand_operand(); b = rand_operand();
      tag = 5'($urandom_range(0, 31));
      exp = ref_model(op, a, b);
      run_op(op, a, b, tag, res, tg, lat);
      n_tests++; if (res !== exp || tg !== tag || lat != ref_latency(op, a, b)) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got res=%h tag=%0d lat=%0d exp res=%h tag=%0d lat=%0d",
                 i, op, a, b, res, tg, lat, exp, tag, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_flush_calc();
    int pulses = 0;
    logic [31:0] res; logic [4:0] tg; int lat;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = 3'd0; bus.a_i = 32'd1234; bus.b_i = 32'd5678; bus.tag_i = 5'd9;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush_i = 1'b1;
    @(posedge clk); #1; bus.flush_i = 1'b0;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_calc_busy got=%b exp=0", bus.busy_o); end
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.out_valid_o) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL flush_calc_no_valid got=%0d pulses exp=0", pulses); end
    run_op(3'd0, 32'd3, 32'd4, 5'd17, res, tg, lat);
    n_tests++; if (res !== 32'd12 || lat != 33) begin n_fail++; $display("FAIL flush_then_mul got=%h lat=%0d exp=0000000c lat=33", res, lat); end
  endtask

  task automatic test_flush_idle();
    int pulses = 0;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 3'd5; bus.a_i = 32'd7; bus.b_i = 32'd0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got=%b exp=0", bus.busy_o); end
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.out_valid_o) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL flush_idle_no_valid got=%0d pulses exp=0", pulses); end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, exp, cap_r; logic [4:0] cap_t; int bad = 0; bit seen = 0;
    a = $urandom; b = $urandom; exp = ref_model(3'd3, a, b);
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = 3'd3; bus.a_i = a; bus.b_i = b; bus.tag_i = 5'd22;
    bus.out_ready_i = 1'b0;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; if (bus.out_valid_o) begin seen = 1; break; end end
    n_tests++; if (!seen || bus.result_o !== exp || bus.tag_o !== 5'd22) begin
      n_fail++; $display("FAIL stall_result valid=%b got=%h tag=%0d exp=%h tag=22", seen, bus.result_o, bus.tag_o, exp);
    end
    cap_r = bus.result_o; cap_t = bus.tag_o;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o !== 1'b1 || bus.result_o !== cap_r || bus.tag_o !== cap_t || bus.in_ready_o !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", bad); end
    @(negedge clk); bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.out_ready_i = 1'b0;
    n_tests++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_release valid=%b ready=%b exp valid=0 ready=1", bus.out_valid_o, bus.in_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.op_i = 3'd1; bus.a_i = 32'hDEADBEEF; bus.b_i = 32'h1234; bus.tag_i = 5'd27;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    n_tests++; if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 ||
                   bus.result_o !== 32'h0 || bus.tag_o !== 5'h0) begin
      n_fail++; $display("FAIL reset_mid busy=%b ready=%b valid=%b res=%h tag=%0d exp 0/1/0/0/0",
                         bus.busy_o, bus.in_ready_o, bus.out_valid_o, bus.result_o, bus.tag_o);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.out_valid_o) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL reset_mid_no_valid got=%0d pulses exp=0", pulses); end
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0; bus.tag_i = '0;
    bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_directed();
    test_random();
    test_flush_calc();
    test_flush_idle();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
